// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM driver arbiter.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int SRAM_ADDR_W = 19;
    localparam int SRAM_DATA_W = 16;

    // Wide enough for the largest legal MAX_BURST (255).
    localparam int BURST_CNT_W = 8;

    function automatic logic [BURST_CNT_W-1:0] sat_inc(
        input logic [BURST_CNT_W-1:0] val,
        input logic [BURST_CNT_W-1:0] lim
    );
        return (val >= lim) ? lim : val + 1'b1;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of both requester ports plus the SRAM driver handshake.
interface sram_port_arbiter_if
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
);

    logic              p0_valid;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_lock;
    logic              p0_ready;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_valid;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_lock;
    logic              p1_ready;
    logic [DATA_W-1:0] p1_rdata;

    logic              m_valid;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;

    logic              grant_id;
    logic              busy;

    modport slave (
        input  p0_valid, p0_we, p0_addr, p0_wdata, p0_lock,
        output p0_ready, p0_rdata,
        input  p1_valid, p1_we, p1_addr, p1_wdata, p1_lock,
        output p1_ready, p1_rdata,
        output m_valid, m_we, m_addr, m_wdata,
        input  m_ready, m_rdata,
        output grant_id, busy
    );

    modport master (
        output p0_valid, p0_we, p0_addr, p0_wdata, p0_lock,
        input  p0_ready, p0_rdata,
        output p1_valid, p1_we, p1_addr, p1_wdata, p1_lock,
        input  p1_ready, p1_rdata,
        input  m_valid, m_we, m_addr, m_wdata,
        output m_ready, m_rdata,
        input  grant_id, busy
    );

endinterface

// File: rtl/sram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin winner select with burst lock; holds last_grant and the
// consecutive-grant counter, both updated on the done strobe.
module rr_arbiter2
    import sram_port_arbiter_pkg::*;
#(
    parameter int MAX_BURST   = 8,
    parameter bit P0_PRIORITY = 1'b1
)(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    input  logic       done,
    input  logic       done_id,
    output logic       winner,
    output logic       any_req
);

    // last_grant starts on the port that should lose the first tie.
    localparam logic                   RST_LAST  = P0_PRIORITY ? PORT_AUX : PORT_CPU;
    localparam logic [BURST_CNT_W-1:0] BURST_LIM = BURST_CNT_W'(MAX_BURST);

    logic                   last_grant_q, last_grant_d;
    logic                   lock_act_q, lock_act_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    assign any_req = |req;

    always_comb begin
        winner = ~last_grant_q;
        if (req == 2'b01) begin
            winner = PORT_CPU;
        end else if (req == 2'b10) begin
            winner = PORT_AUX;
        end else if (lock_act_q && (burst_cnt_q < BURST_LIM)) begin
            winner = last_grant_q;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        lock_act_d   = lock_act_q;
        burst_cnt_d  = burst_cnt_q;
        if (done) begin
            last_grant_d = done_id;
            lock_act_d   = lock[done_id];
            if (lock[done_id] && (done_id == last_grant_q)) begin
                burst_cnt_d = sat_inc(burst_cnt_q, BURST_LIM);
            end else begin
                burst_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant_q <= RST_LAST;
            lock_act_q   <= 1'b0;
            burst_cnt_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_act_q   <= lock_act_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM driver between a CPU port and an auxiliary port; one driver
// transaction in flight, requests captured in IDLE, responses registered.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int MAX_BURST   = 8,
    parameter bit P0_PRIORITY = 1'b1
)(
    input  logic               clk,
    input  logic               resetn,
    sram_port_arbiter_if.slave bus
);

    state_t            state_q, state_d;
    logic              m_valid_q, m_valid_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              grant_q, grant_d;
    logic [1:0]        ready_q, ready_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              busy_q, busy_d;

    logic              winner;
    logic              any_req;

    rr_arbiter2 #(
        .MAX_BURST   (MAX_BURST),
        .P0_PRIORITY (P0_PRIORITY)
    ) u_rr (
        .clk     (clk),
        .resetn  (resetn),
        .req     ({bus.p1_valid, bus.p0_valid}),
        .lock    ({bus.p1_lock, bus.p0_lock}),
        .done    (state_q == ST_RESP),
        .done_id (grant_q),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        state_d    = state_q;
        m_valid_d  = m_valid_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        grant_d    = grant_q;
        ready_d    = 2'b00;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d   = winner;
                    m_we_d    = (winner == PORT_AUX) ? bus.p1_we    : bus.p0_we;
                    m_addr_d  = (winner == PORT_AUX) ? bus.p1_addr  : bus.p0_addr;
                    m_wdata_d = (winner == PORT_AUX) ? bus.p1_wdata : bus.p0_wdata;
                    m_valid_d = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.m_ready) begin
                    m_valid_d        = 1'b0;
                    ready_d[grant_q] = 1'b1;
                    state_d          = ST_RESP;
                    // Writes leave the port's last read data untouched.
                    if (!m_we_q) begin
                        if (grant_q == PORT_AUX) begin
                            p1_rdata_d = bus.m_rdata;
                        end else begin
                            p0_rdata_d = bus.m_rdata;
                        end
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                m_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            m_valid_q  <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            grant_q    <= PORT_CPU;
            ready_q    <= 2'b00;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_valid_q  <= m_valid_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            grant_q    <= grant_d;
            ready_q    <= ready_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.m_valid  = m_valid_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = busy_q;
    assign bus.p0_ready = ready_q[0];
    assign bus.p1_ready = ready_q[1];
    assign bus.p0_rdata = p0_rdata_q;
    assign bus.p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: driver model, expected-transaction
// queue filled at stimulus time, popped and compared on each pN_ready.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    localparam int LAT  = 3;
    localparam int MAXB = 4;

    typedef struct {
        logic        port;
        logic        we;
        logic [18:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(19), .DATA_W(16)) bus ();

    sram_port_arbiter #(
        .ADDR_W      (19),
        .DATA_W      (16),
        .MAX_BURST   (MAXB),
        .P0_PRIORITY (1'b1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mr_cyc   = -10;

    exp_t        sb[$];
    logic [15:0] mem [logic [18:0]];
    logic [15:0] exp_last_rd [2];

    logic drv_ready  = 1'b0;
    logic spur_ready = 1'b0;
    assign bus.m_ready = drv_ready | spur_ready;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [18:0] a);
        if (mem.exists(a)) return mem[a];
        return a[15:0] ^ 16'hA5C3;
    endfunction

    task automatic push(input logic port, input logic we, input logic [18:0] addr,
                        input logic [15:0] wdata);
        exp_t e;
        e.port  = port;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        if (!we) exp_last_rd[port] = mem_rd(addr);
        e.rdata = exp_last_rd[port];
        sb.push_back(e);
    endtask

    task automatic set_req(input logic port, input logic we, input logic [18:0] addr,
                           input logic [15:0] wdata, input logic lock);
        if (port) begin
            bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_lock = lock;
        end else begin
            bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_lock = lock;
        end
    endtask

    // Hold each port's request until it has completed nN transactions.
    task automatic run_ports(input int n0, input int n1, input string tag);
        int rem0;
        int rem1;
        int c;
        rem0 = n0;
        rem1 = n1;
        c = 0;
        bus.p0_valid = (n0 > 0);
        bus.p1_valid = (n1 > 0);
        while ((rem0 > 0 || rem1 > 0) && c < 400) begin
            @(negedge clk);
            c++;
            if (bus.p0_ready) begin
                rem0--;
                if (rem0 <= 0) bus.p0_valid = 1'b0;
            end
            if (bus.p1_ready) begin
                rem1--;
                if (rem1 <= 0) bus.p1_valid = 1'b0;
            end
        end
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
        chk({tag, "_done"}, 32'(rem0 <= 0 && rem1 <= 0), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // SRAM driver model: m_ready LAT cycles after m_valid, checks request stability.
    initial begin : driver
        int          vcnt;
        logic        iss_we;
        logic [18:0] iss_addr;
        logic [15:0] iss_wdata;
        vcnt = 0;
        iss_we = 1'b0;
        iss_addr = '0;
        iss_wdata = '0;
        bus.m_rdata = '0;
        forever begin
            @(negedge clk);
            if (!resetn || !bus.m_valid) begin
                drv_ready = 1'b0;
                vcnt = 0;
            end else begin
                vcnt++;
                if (vcnt == 1) begin
                    chk("issue_sb_nonempty", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        chk("issue_grant", 32'(bus.grant_id), 32'(sb[0].port));
                        chk("issue_we", 32'(bus.m_we), 32'(sb[0].we));
                        chk("issue_addr", 32'(bus.m_addr), 32'(sb[0].addr));
                        if (sb[0].we) chk("issue_wdata", 32'(bus.m_wdata), 32'(sb[0].wdata));
                        chk("issue_busy", 32'(bus.busy), 32'd1);
                    end
                    iss_we = bus.m_we;
                    iss_addr = bus.m_addr;
                    iss_wdata = bus.m_wdata;
                end else begin
                    chk("stable_we", 32'(bus.m_we), 32'(iss_we));
                    chk("stable_addr", 32'(bus.m_addr), 32'(iss_addr));
                    chk("stable_wdata", 32'(bus.m_wdata), 32'(iss_wdata));
                end
                if (vcnt == LAT) begin
                    drv_ready = 1'b1;
                    mr_cyc = cyc;
                    if (bus.m_we) mem[bus.m_addr] = bus.m_wdata;
                    else bus.m_rdata = mem_rd(bus.m_addr);
                end else begin
                    drv_ready = 1'b0;
                end
            end
        end
    end

    // Response monitor: every pN_ready pops one expected transaction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.p0_ready || bus.p1_ready) begin
                chk("ready_onehot", 32'(bus.p0_ready & bus.p1_ready), 32'd0);
                chk("ready_sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("ready_port", 32'(bus.p1_ready), 32'(e.port));
                    chk("ready_latency", 32'(cyc), 32'(mr_cyc + 1));
                    chk("ready_rdata", 32'(e.port ? bus.p1_rdata : bus.p0_rdata), 32'(e.rdata));
                end
            end
        end
    end

    initial begin : stim
        bit seen;
        resetn = 1'b0;
        bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
        set_req(1'b0, 1'b0, 19'h0, 16'h0, 1'b0);
        set_req(1'b1, 1'b0, 19'h0, 16'h0, 1'b0);
        mem[19'h00123] = 16'hBEEF;
        exp_last_rd[0] = '0;
        exp_last_rd[1] = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_p0_ready", 32'(bus.p0_ready), 32'd0);
        chk("rst_p1_ready", 32'(bus.p1_ready), 32'd0);
        chk("rst_p0_rdata", 32'(bus.p0_rdata), 32'd0);
        chk("rst_p1_rdata", 32'(bus.p1_rdata), 32'd0);
        chk("rst_m_addr", 32'(bus.m_addr), 32'd0);
        chk("rst_m_we", 32'(bus.m_we), 32'd0);
        resetn = 1'b1;

        // Simultaneous requests right after reset: port 0 first, then alternate
        set_req(1'b0, 1'b0, 19'h00010, 16'h0, 1'b0);
        set_req(1'b1, 1'b0, 19'h40010, 16'h0, 1'b0);
        push(1'b0, 1'b0, 19'h00010, 16'h0);
        push(1'b1, 1'b0, 19'h40010, 16'h0);
        push(1'b0, 1'b0, 19'h00010, 16'h0);
        push(1'b1, 1'b0, 19'h40010, 16'h0);
        run_ports(2, 2, "t2");

        // Single port 0 read returning 0xBEEF
        set_req(1'b0, 1'b0, 19'h00123, 16'h0, 1'b0);
        push(1'b0, 1'b0, 19'h00123, 16'h0);
        run_ports(1, 0, "t1");
        chk("t1_p0_rdata_held", 32'(bus.p0_rdata), 32'h0000BEEF);

        // Port 1 locked against a continuously requesting port 0: 5 grants then port 0
        set_req(1'b1, 1'b0, 19'h00200, 16'h0, 1'b1);
        set_req(1'b0, 1'b0, 19'h00300, 16'h0, 1'b0);
        for (int i = 0; i < MAXB + 1; i++) push(1'b1, 1'b0, 19'h00200, 16'h0);
        push(1'b0, 1'b0, 19'h00300, 16'h0);
        push(1'b1, 1'b0, 19'h00200, 16'h0);
        run_ports(1, MAXB + 2, "t3");
        bus.p1_lock = 1'b0;

        // Port 1 write at top address leaves p1_rdata unchanged
        set_req(1'b1, 1'b1, 19'h7FFFF, 16'h5A5A, 1'b0);
        push(1'b1, 1'b1, 19'h7FFFF, 16'h5A5A);
        run_ports(0, 1, "t4");
        chk("t4_p1_rdata_kept", 32'(bus.p1_rdata), 32'(mem_rd(19'h00200)));
        chk("t4_mem_written", 32'(mem_rd(19'h7FFFF)), 32'h00005A5A);

        // Spurious m_ready while idle
        @(negedge clk);
        spur_ready = 1'b1;
        @(negedge clk);
        spur_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_busy", 32'(bus.busy), 32'd0);
            chk("t6_m_valid", 32'(bus.m_valid), 32'd0);
            chk("t6_ready", 32'({bus.p1_ready, bus.p0_ready}), 32'd0);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of ISSUE
        set_req(1'b0, 1'b0, 19'h00456, 16'h0, 1'b0);
        push(1'b0, 1'b0, 19'h00456, 16'h0);
        bus.p0_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.m_valid) seen = 1'b1;
        end
        chk("t5_issue_seen", 32'(seen), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("t5_m_valid_async", 32'(bus.m_valid), 32'd0);
        chk("t5_busy_async", 32'(bus.busy), 32'd0);
        bus.p0_valid = 1'b0;
        sb.delete();
        exp_last_rd[0] = '0;
        exp_last_rd[1] = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_ready", 32'({bus.p1_ready, bus.p0_ready}), 32'd0);
        end
        chk("t5_p0_rdata_cleared", 32'(bus.p0_rdata), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        push(1'b0, 1'b0, 19'h00456, 16'h0);
        run_ports(1, 0, "t5b");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
